// File: rtl/sub8_serial_pkg.sv
// sub8_serial_pkg
// Shared definitions for the bit-serial subtractor:
//   state_t       - controller state encoding (IDLE, SHIFT, DONE), 2 bits
//   DEFAULT_WIDTH - operand width shared with the 8-bit ripple-carry adder
package sub8_serial_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/fa.sv
// fa
// Single-bit full-adder cell, shared with the ripple-carry adder.
// Ports:
//   a, b, cin - addend bits and carry-in
//   s, cout   - sum bit and carry-out
module fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/sub8_serial.sv
// sub8_serial
// Bit-serial subtractor: d = a - b - bin, one bit per clock over width
// cycles, using a single fa cell as a + ~b + ~bin.
// Ports:
//   clk, rst   - clock (rising edge), asynchronous active-high reset
//   start      - request, accepted in IDLE or DONE
//   a, b, bin  - operands, captured on the accepting edge
//   busy       - high while bits are being processed
//   done       - one-cycle pulse when d/bout are updated
//   d, bout    - registered difference and borrow-out
//   ovf        - registered signed overflow (only with SUB8_SERIAL_OVF_EN)
// Optional feature macro: SUB8_SERIAL_OVF_EN adds the ovf output.
module sub8_serial
  import sub8_serial_pkg::*;
#(
  parameter int width = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(width)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [width-1:0] d,
  output logic             bout
`ifdef SUB8_SERIAL_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(width - 1);

  state_t             state_q, state_d;
  logic [width-1:0]   sa_q, sa_d;
  logic [width-1:0]   sb_q, sb_d;
  logic [width-1:0]   res_q, res_d;
  logic [width-1:0]   d_q, d_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               bout_q, bout_d;
  logic               sum, cout;
`ifdef SUB8_SERIAL_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  // The one and only bit slice; subtraction is a + ~b + ~bin.
  fa u_fa (
    .a   (sa_q[0]),
    .b   (sb_q[0]),
    .cin (carry_q),
    .s   (sum),
    .cout(cout)
  );

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    res_d   = res_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    bout_d  = bout_q;
`ifdef SUB8_SERIAL_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      // DONE accepts a new start exactly like IDLE for back-to-back use.
      IDLE, DONE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = ~b;
          carry_d = ~bin;
          cnt_d   = '0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        // LSB first: each sum bit enters at the MSB, so after width
        // shifts bit 0 has reached the LSB.
        res_d   = {sum, res_q[width-1:1]};
        sa_d    = sa_q >> 1;
        sb_d    = sb_q >> 1;
        carry_d = cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          d_d     = res_d;
          bout_d  = ~cout;   // no carry out of a + ~b + ~bin means a borrow
`ifdef SUB8_SERIAL_OVF_EN
          ovf_d   = carry_q ^ cout;  // carry into MSB vs carry out of MSB
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      res_q   <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      bout_q  <= 1'b0;
`ifdef SUB8_SERIAL_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      res_q   <= res_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      bout_q  <= bout_d;
`ifdef SUB8_SERIAL_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign d    = d_q;
  assign bout = bout_q;
`ifdef SUB8_SERIAL_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_sub8_serial.sv
// tb_sub8_serial
// Self-checking bench for sub8_serial: expected results are pushed to a
// scoreboard queue when an operation is started and popped when done pulses.
module tb_sub8_serial;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       bin = 1'b0;
  logic       busy, done, bout;
  logic [7:0] d;
`ifdef SUB8_SERIAL_OVF_EN
  logic       ovf;
`endif

  typedef struct {
    logic [7:0] d;
    logic       bout;
    logic       ovf;
  } exp_t;

  exp_t sb_q[$];
  int   vectors = 0;
  int   errors  = 0;

  sub8_serial dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .bin  (bin),
    .busy (busy),
    .done (done),
    .d    (d),
    .bout (bout)
`ifdef SUB8_SERIAL_OVF_EN
    ,
    .ovf  (ovf)
`endif
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [7:0] ta, input logic [7:0] tb, input logic tbin);
    exp_t e;
    int   diff;
    diff   = int'(ta) - int'(tb) - int'(tbin);
    e.d    = diff[7:0];
    e.bout = (diff < 0);
    e.ovf  = (ta[7] != tb[7]) && (e.d[7] != ta[7]);
    return e;
  endfunction

  // Present operands, let the next rising edge accept them, drop start.
  task automatic start_op(input logic [7:0] ta, input logic [7:0] tb, input logic tbin);
    a = ta; b = tb; bin = tbin; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts negedges after the accepting edge until done is seen (bounded).
  task automatic wait_done(output int cyc, output int busy_cyc, output bit got, output bit overlap);
    cyc = 0; busy_cyc = 0; got = 0; overlap = 0;
    while (cyc < 40 && !got) begin
      @(negedge clk);
      cyc++;
      if (busy) busy_cyc++;
      if (busy && done) overlap = 1;
      if (done) got = 1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({busy, done, d, bout} !== 11'b0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b d=%h bout=%b, want all 0", busy, done, d, bout);
    end
`ifdef SUB8_SERIAL_OVF_EN
    vectors++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_ovf: got %b want 0", ovf);
    end
`endif
    rst = 1'b0;
    @(negedge clk);
  endtask

  // One full operation with latency, busy-length and scoreboard checks.
  task automatic do_op(input string name, input logic [7:0] ta, input logic [7:0] tb, input logic tbin);
    int cyc, bc; bit got, ov; exp_t e;
    sb_q.push_back(model(ta, tb, tbin));
    start_op(ta, tb, tbin);
    wait_done(cyc, bc, got, ov);
    vectors++;
    if (!got || cyc != 9 || bc != 8 || ov) begin
      errors++;
      $display("FAIL %s_timing: got done=%b at cycle %0d busy=%0d overlap=%b, want done at 9 busy=8", name, got, cyc, bc, ov);
    end
    if (got && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      vectors++;
      if (d !== e.d || bout !== e.bout) begin
        errors++;
        $display("FAIL %s_result: got d=%h bout=%b want d=%h bout=%b (a=%h b=%h bin=%b)", name, d, bout, e.d, e.bout, ta, tb, tbin);
      end
`ifdef SUB8_SERIAL_OVF_EN
      vectors++;
      if (ovf !== e.ovf) begin
        errors++;
        $display("FAIL %s_ovf: got %b want %b", name, ovf, e.ovf);
      end
`endif
    end else begin
      sb_q.delete();
    end
    @(negedge clk);  // back to IDLE
  endtask

  task automatic test_basic;
    do_op("basic", 8'h05, 8'h03, 1'b0);
  endtask

  task automatic test_borrow;
    do_op("borrow_wrap", 8'h00, 8'h01, 1'b0);
    do_op("borrow_bin", 8'h10, 8'h0F, 1'b1);
    do_op("zero_minus_bin", 8'h00, 8'h00, 1'b1);
  endtask

  task automatic test_overflow;
    do_op("ovf_set", 8'h80, 8'h01, 1'b0);
    do_op("ovf_clear", 8'h7F, 8'h01, 1'b0);
  endtask

  // start held high and operands scrambled during busy: only the first
  // operands count, one done pulse.
  task automatic test_start_held;
    exp_t e; int bc = 0, dn = 0, cyc = 0; bit ov = 0;
    e = model(8'h33, 8'h11, 1'b0);
    a = 8'h33; b = 8'h11; bin = 1'b0; start = 1'b1;
    @(posedge clk);
    while (cyc < 40 && dn == 0) begin
      @(negedge clk);
      cyc++;
      if (busy) bc++;
      if (busy && done) ov = 1;
      if (done) begin
        dn++;
        start = 1'b0;
        vectors++;
        if (d !== e.d || bout !== e.bout) begin
          errors++;
          $display("FAIL held_result: got d=%h bout=%b want d=%h bout=%b", d, bout, e.d, e.bout);
        end
      end else begin
        a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
      end
    end
    start = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done) dn++;
    end
    vectors++;
    if (bc != 8 || dn != 1 || ov) begin
      errors++;
      $display("FAIL held_handshake: got busy=%0d done_pulses=%0d overlap=%b, want busy=8 done_pulses=1", bc, dn, ov);
    end
  endtask

  task automatic test_back_to_back;
    exp_t e1, e2; int cyc, bc; bit got, ov; bit held = 1;
    e1 = model(8'h50, 8'h20, 1'b0);
    e2 = model(8'h12, 8'h34, 1'b1);
    sb_q.push_back(e1);
    start_op(8'h50, 8'h20, 1'b0);
    wait_done(cyc, bc, got, ov);
    if (got) e1 = sb_q.pop_front(); else sb_q.delete();
    vectors++;
    if (!got || d !== e1.d) begin
      errors++;
      $display("FAIL b2b_first: got done=%b d=%h want d=%h", got, d, e1.d);
    end
    // still in the DONE cycle: restart immediately
    sb_q.push_back(e2);
    start_op(8'h12, 8'h34, 1'b1);
    cyc = 0; got = 0;
    while (cyc < 40 && !got) begin
      @(negedge clk);
      cyc++;
      if (done) got = 1;
      else if (d !== e1.d) held = 0;
    end
    vectors++;
    if (!held) begin
      errors++;
      $display("FAIL b2b_hold: d changed before second done, want %h held", e1.d);
    end
    vectors++;
    if (!got || cyc != 9) begin
      errors++;
      $display("FAIL b2b_latency: got done=%b at cycle %0d want cycle 9", got, cyc);
    end
    if (got) e2 = sb_q.pop_front(); else sb_q.delete();
    vectors++;
    if (d !== e2.d || bout !== e2.bout) begin
      errors++;
      $display("FAIL b2b_second: got d=%h bout=%b want d=%h bout=%b", d, bout, e2.d, e2.bout);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int dn = 0;
    do_op("pre_reset", 8'hC3, 8'h41, 1'b0);   // leaves d nonzero
    start_op(8'h99, 8'h11, 1'b0);
    repeat (4) @(negedge clk);                // 4th SHIFT cycle
    rst = 1'b1;
    #1;
    vectors++;
    if ({busy, done, d, bout} !== 11'b0) begin
      errors++;
      $display("FAIL reset_mid: got busy=%b done=%b d=%h bout=%b, want all 0", busy, done, d, bout);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done) dn++;
    end
    vectors++;
    if (dn != 0 || d !== 8'h00) begin
      errors++;
      $display("FAIL reset_no_done: got done_pulses=%0d d=%h want 0 and 00", dn, d);
    end
    do_op("post_reset", 8'h99, 8'h11, 1'b0);
  endtask

  task automatic test_random;
    do_op("ff_ff_1", 8'hFF, 8'hFF, 1'b1);
    for (int i = 0; i < 1000; i++)
      do_op("random", 8'($urandom), 8'($urandom), 1'($urandom));
  endtask

  initial begin
    test_reset;
    test_basic;
    test_borrow;
    test_overflow;
    test_start_held;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
